// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath blocks.
//   - datapath width default
//   - load/store width codes
//   - alignment and byte-lane helpers
package mips_pkg;

  localparam int NB_DATA_DEF = 32;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_RSVD = 2'b10,
    W_WORD = 2'b11
  } width_e;

  // The reserved code behaves like a word access.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width_e'(width))
      W_BYTE:  return 1'b0;
      W_HALF:  return offset[0];
      default: return (offset != 2'b00);
    endcase
  endfunction

  // Byte lanes touched by an aligned access.
  function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] offset);
    case (width_e'(width))
      W_BYTE:  return 4'b0001 << offset;
      W_HALF:  return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-enabled data memory for the MEM stage.
//   clk       clock
//   rst_n     asynchronous active-low reset (debug output register only)
//   wr_en     per-byte write enables, applied on the rising edge
//   wr_addr   write word index
//   wr_data   write data, already replicated onto the enabled lanes
//   rd_addr   asynchronous read word index
//   rd_data   asynchronous read data (pre-write contents in the write cycle)
//   dbg_addr  debug read word index
//   dbg_data  registered debug read data
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data,
  input  logic [NB_ADDR-1:0] dbg_addr,
  output logic [NB_DATA-1:0] dbg_data
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Array contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en[b]) begin
        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
    end
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline.
// The execute-stage result is the byte address into a byte-enabled data
// memory; stores write selected lanes, loads select and extend a lane and
// the result is captured in the MEM/WB register.
//   clk, i_rst_n      clock, asynchronous active-low reset
//   i_halt            debug freeze: holds MEM/WB outputs, blocks stores
//   i_mem2reg, i_regWrite, i_write_reg   control passed to WB
//   i_memRead, i_memWrite                load / store in this stage
//   i_width, i_sign_flag                 access width and load extension
//   i_result, i_data4Mem                 byte address, store data
//   i_dbg_addr, o_dbg_data               registered debug word read
//   o_mem2reg, o_regWrite, o_write_reg, o_read_data, o_alu_result, o_misaligned
module memory_access
  import mips_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_mem2reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_dbg_data
);

  logic [1:0]         offset;
  logic [NB_ADDR-1:0] word_idx;
  logic               misaligned;
  logic [3:0]         wr_en;
  logic [NB_DATA-1:0] wr_data;
  logic [NB_DATA-1:0] rd_word;
  logic [NB_DATA-1:0] rd_lane;
  logic [NB_DATA-1:0] load_data;
  logic               unused_addr_hi;

  // Address bits above the array are dropped, giving modulo wrap-around.
  assign offset         = i_result[1:0];
  assign word_idx       = i_result[NB_ADDR+1:2];
  assign unused_addr_hi = ^i_result[NB_DATA-1:NB_ADDR+2];

  assign misaligned = is_misaligned(i_width, offset);

  // Reset is folded in so a store caught by reset assertion never lands.
  assign wr_en = (i_memWrite && !misaligned && !i_halt && i_rst_n)
                 ? lane_mask(i_width, offset) : 4'b0000;

  always_comb begin
    case (width_e'(i_width))
      W_BYTE:  wr_data = {4{i_data4Mem[7:0]}};
      W_HALF:  wr_data = {2{i_data4Mem[15:0]}};
      default: wr_data = i_data4Mem;
    endcase
  end

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .clk      (clk),
    .rst_n    (i_rst_n),
    .wr_en    (wr_en),
    .wr_addr  (word_idx),
    .wr_data  (wr_data),
    .rd_addr  (word_idx),
    .rd_data  (rd_word),
    .dbg_addr (i_dbg_addr),
    .dbg_data (o_dbg_data)
  );

  function automatic logic [NB_DATA-1:0] extend_load(input logic [NB_DATA-1:0] lane,
                                                      input logic [1:0]         width,
                                                      input logic               sgn);
    case (width_e'(width))
      W_BYTE:  return {{(NB_DATA-8){sgn & lane[7]}}, lane[7:0]};
      W_HALF:  return {{(NB_DATA-16){sgn & lane[15]}}, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 before extension.
  assign rd_lane   = rd_word >> {offset, 3'b000};
  assign load_data = (i_memRead && !misaligned)
                     ? extend_load(rd_lane, i_width, i_sign_flag) : '0;

  // ---- MEM/WB register ----
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem2reg    <= 1'b0;
      o_regWrite   <= 1'b0;
      o_write_reg  <= '0;
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_misaligned <= 1'b0;
    end else if (!i_halt) begin
      o_mem2reg    <= i_mem2reg;
      o_regWrite   <= i_regWrite && !(i_memRead && misaligned);
      o_write_reg  <= i_write_reg;
      o_read_data  <= load_data;
      o_alu_result <= i_result;
      o_misaligned <= (i_memRead || i_memWrite) && misaligned;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam int NBYTES  = 4 << NB_ADDR;

  logic               clk;
  logic               i_rst_n;
  logic               i_halt;
  logic               i_mem2reg;
  logic               i_memRead;
  logic               i_memWrite;
  logic               i_regWrite;
  logic [1:0]         i_width;
  logic               i_sign_flag;
  logic [4:0]         i_write_reg;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] i_data4Mem;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic               o_mem2reg;
  logic               o_regWrite;
  logic [4:0]         o_write_reg;
  logic [NB_DATA-1:0] o_read_data;
  logic [NB_DATA-1:0] o_alu_result;
  logic               o_misaligned;
  logic [NB_DATA-1:0] o_dbg_data;

  memory_access #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_halt       (i_halt),
    .i_mem2reg    (i_mem2reg),
    .i_memRead    (i_memRead),
    .i_memWrite   (i_memWrite),
    .i_regWrite   (i_regWrite),
    .i_width      (i_width),
    .i_sign_flag  (i_sign_flag),
    .i_write_reg  (i_write_reg),
    .i_result     (i_result),
    .i_data4Mem   (i_data4Mem),
    .i_dbg_addr   (i_dbg_addr),
    .o_mem2reg    (o_mem2reg),
    .o_regWrite   (o_regWrite),
    .o_write_reg  (o_write_reg),
    .o_read_data  (o_read_data),
    .o_alu_result (o_alu_result),
    .o_misaligned (o_misaligned),
    .o_dbg_data   (o_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain byte array plus the expected MEM/WB contents.
  bit   [7:0]  mb [NBYTES];
  logic        e_m2r, e_rw, e_mis;
  logic [4:0]  e_wreg;
  logic [31:0] e_rd, e_alu, e_dbg;
  bit          dbg_chk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model_outputs();
    e_m2r = 0; e_rw = 0; e_mis = 0; e_wreg = 0; e_rd = 0; e_alu = 0; e_dbg = 0;
  endtask

  function automatic logic [31:0] model_word(input int widx);
    logic [31:0] w = 0;
    for (int k = 0; k < 4; k++) w |= 32'(mb[widx*4 + k]) << (8*k);
    return w;
  endfunction

  task automatic step(input logic wr, input logic rd, input logic rw, input logic m2r,
                      input logic [1:0] w, input logic sg, input logic [4:0] wreg,
                      input logic [31:0] res, input logic [31:0] dat,
                      input logic [7:0] dbg, input logic hlt);
    int          size;
    int          a;
    bit          mis;
    logic [63:0] val;
    @(negedge clk);
    i_memWrite = wr; i_memRead = rd; i_regWrite = rw; i_mem2reg = m2r;
    i_width = w; i_sign_flag = sg; i_write_reg = wreg; i_result = res;
    i_data4Mem = dat; i_dbg_addr = dbg; i_halt = hlt;

    size = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    a    = int'(res) & (NBYTES - 1);
    mis  = (a % size) != 0;
    val  = 0;
    if (!mis) for (int k = 0; k < size; k++) val |= 64'(mb[a + k]) << (8*k);
    if (sg && size < 4 && val[8*size-1]) val |= ~((64'd1 << (8*size)) - 1);
    e_dbg = model_word(int'(dbg));
    if (!hlt) begin
      e_m2r  = m2r;
      e_wreg = wreg;
      e_alu  = res;
      e_rd   = (rd && !mis) ? val[31:0] : 32'h0;
      e_rw   = rw && !(rd && mis);
      e_mis  = (rd || wr) && mis;
      if (wr && !mis) for (int k = 0; k < size; k++) mb[a + k] = dat[8*k +: 8];
    end

    @(posedge clk); #1;
    chk("read_data", o_read_data, e_rd);
    chk("regWrite", 32'(o_regWrite), 32'(e_rw));
    chk("misaligned", 32'(o_misaligned), 32'(e_mis));
    chk("mem2reg", 32'(o_mem2reg), 32'(e_m2r));
    chk("write_reg", 32'(o_write_reg), 32'(e_wreg));
    chk("alu_result", o_alu_result, e_alu);
    if (dbg_chk) chk("dbg_data", o_dbg_data, e_dbg);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_data"}, o_read_data, 0);
    chk({tag, "_regWrite"}, 32'(o_regWrite), 0);
    chk({tag, "_misaligned"}, 32'(o_misaligned), 0);
    chk({tag, "_mem2reg"}, 32'(o_mem2reg), 0);
    chk({tag, "_write_reg"}, 32'(o_write_reg), 0);
    chk({tag, "_alu_result"}, o_alu_result, 0);
    chk({tag, "_dbg_data"}, o_dbg_data, 0);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  w;
    logic        sg;
    logic [31:0] res;
    logic [31:0] dat;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_rw;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] r;
    logic [31:0] res;
    logic [1:0]  w;
    logic        wr, rd;

    // Little-endian: 0xDEADBEEF holds EF,BE,AD,DE at offsets 0..3.
    tbl[0]  = '{1, 0, 2'b11, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0};
    tbl[1]  = '{0, 1, 2'b11, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1};
    tbl[2]  = '{0, 1, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 1};
    tbl[3]  = '{0, 1, 2'b00, 0, 32'h13, 32'h0,        32'h000000DE, 0, 1};
    tbl[4]  = '{0, 1, 2'b01, 1, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 1};
    tbl[5]  = '{0, 1, 2'b01, 0, 32'h10, 32'h0,        32'h0000BEEF, 0, 1};
    tbl[6]  = '{1, 0, 2'b00, 0, 32'h11, 32'h000000AA, 32'h0,        0, 0};
    tbl[7]  = '{0, 1, 2'b11, 0, 32'h10, 32'h0,        32'hDEADAAEF, 0, 1};
    tbl[8]  = '{1, 0, 2'b01, 0, 32'h12, 32'h00001234, 32'h0,        0, 0};
    tbl[9]  = '{0, 1, 2'b11, 0, 32'h10, 32'h0,        32'h1234AAEF, 0, 1};
    tbl[10] = '{1, 0, 2'b11, 0, 32'h20, 32'hCAFEF00D, 32'h0,        0, 0};
    tbl[11] = '{1, 0, 2'b11, 0, 32'h21, 32'h11111111, 32'h0,        1, 0};
    tbl[12] = '{0, 1, 2'b01, 1, 32'h23, 32'h0,        32'h0,        1, 0};
    tbl[13] = '{0, 1, 2'b10, 0, 32'h22, 32'h0,        32'h0,        1, 0};
    tbl[14] = '{0, 1, 2'b11, 0, 32'h20, 32'h0,        32'hCAFEF00D, 0, 1};

    i_rst_n = 0; i_halt = 0; i_mem2reg = 0; i_memRead = 0; i_memWrite = 0;
    i_regWrite = 0; i_width = 0; i_sign_flag = 0; i_write_reg = 0;
    i_result = 0; i_data4Mem = 0; i_dbg_addr = 0;
    clear_model_outputs();
    dbg_chk = 0;

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) i_rst_n = 1;

    // Give words 0..63 known contents so every later read is predictable.
    for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 2'b11, 0, 5'(i), 32'(i*4), $urandom, 0, 0);
    dbg_chk = 1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].rd, tbl[i].rd, tbl[i].w, tbl[i].sg, 5'(i + 1),
           tbl[i].res, tbl[i].dat, 8'h4, 0);
      chk($sformatf("tbl%0d_read_data", i), o_read_data, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_misaligned", i), 32'(o_misaligned), 32'(tbl[i].exp_mis));
      chk($sformatf("tbl%0d_regWrite", i), 32'(o_regWrite), 32'(tbl[i].exp_rw));
    end

    // Halted store: outputs keep the last load's values, word 1 untouched.
    step(1, 0, 0, 0, 2'b11, 0, 5'd30, 32'h04, 32'h55, 8'h1, 1);
    step(1, 0, 0, 0, 2'b11, 0, 5'd30, 32'h04, 32'h55, 8'h1, 1);
    chk("halt_read_data", o_read_data, 32'hCAFEF00D);
    chk("halt_alu_result", o_alu_result, 32'h20);
    chk("halt_write_reg", 32'(o_write_reg), 32'd15);
    step(1, 0, 0, 0, 2'b11, 0, 5'd30, 32'h04, 32'h55, 8'h1, 0);
    step(0, 0, 0, 0, 2'b11, 0, 5'd0, 32'h0, 32'h0, 8'h1, 0);
    chk("halt_release_dbg", o_dbg_data, 32'h00000055);

    // Reset asserted mid-cycle with a store pending.
    @(negedge clk);
    i_memWrite = 1; i_width = 2'b11; i_result = 32'h08; i_data4Mem = 32'h77;
    i_dbg_addr = 8'h2;
    #1 i_rst_n = 0;
    #1 chk_all_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    i_rst_n = 1; i_memWrite = 0;
    clear_model_outputs();
    step(0, 0, 0, 0, 2'b11, 0, 5'd0, 32'h0, 32'h0, 8'h2, 0);
    step(0, 0, 0, 0, 2'b11, 0, 5'd0, 32'h0, 32'h0, 8'h4, 0);
    chk("reset_retained_dbg", o_dbg_data, 32'h1234AAEF);

    // Random traffic over words 0..63 with random upper address bits.
    for (int i = 0; i < 400; i++) begin
      r   = $urandom;
      res = (r & 32'hFFFFFC00) | 32'($urandom_range(0, 255));
      w   = 2'($urandom_range(0, 3));
      wr  = ($urandom_range(0, 9) < 4);
      rd  = wr ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
      step(wr, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), res, $urandom,
           8'($urandom_range(0, 63)), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
